// File: rtl/dlsc_pcie_s6_inbound_write_core.sv
// Inbound PCIe write TLPs to AXI write bursts split at 2^LEN beats and 4KB pages; 1-cycle W register.
// Backpressure: header held in IDLE only, payload gated by AW ordering, W ready and 15 outstanding bursts.
module dlsc_pcie_s6_inbound_write_core #(
  parameter int ADDR = 32,
  parameter int LEN  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tlp_h_ready,
  input  logic            tlp_h_valid,
  input  logic [ADDR-1:2] tlp_h_addr,
  input  logic [9:0]      tlp_h_len,
  input  logic [3:0]      tlp_h_be_first,
  input  logic [3:0]      tlp_h_be_last,
  output logic            tlp_d_ready,
  input  logic            tlp_d_valid,
  input  logic [31:0]     tlp_d_data,
  input  logic            axi_aw_ready,
  output logic            axi_aw_valid,
  output logic [ADDR-1:0] axi_aw_addr,
  output logic [LEN-1:0]  axi_aw_len,
  input  logic            axi_w_ready,
  output logic            axi_w_valid,
  output logic            axi_w_last,
  output logic [3:0]      axi_w_strb,
  output logic [31:0]     axi_w_data,
  output logic            axi_b_ready,
  input  logic            axi_b_valid,
  input  logic [1:0]      axi_b_resp,
  output logic            err_resp
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

  state_t          state_q, state_d;
  logic [ADDR-3:0] addr_q, addr_d;
  logic [10:0]     remain_q, remain_d;
  logic [3:0]      be_first_q, be_first_d;
  logic [3:0]      be_last_q, be_last_d;
  logic            first_q, first_d;
  logic [LEN:0]    beats_q, beats_d;
  logic            aw_vld_q, aw_vld_d;
  logic            w_vld_q, w_vld_d;
  logic            w_last_q, w_last_d;
  logic [3:0]      w_strb_q, w_strb_d;
  logic [31:0]     w_dat_q, w_dat_d;
  logic [3:0]      outst_q, outst_d;
  logic            err_q, err_d;

  logic [10:0] to_4k, max_burst, blen;
  logic        h_acc, aw_hs, w_take, d_acc, last_dword;

  // Burst is clipped by remaining payload, the AXI length limit and the 4KB page edge.
  always_comb begin
    to_4k     = 11'd1024 - {1'b0, addr_q[9:0]};
    max_burst = 11'd1 << LEN;
    blen      = remain_q;
    if (max_burst < blen) blen = max_burst;
    if (to_4k < blen)     blen = to_4k;
  end

  assign h_acc      = tlp_h_ready && tlp_h_valid;
  assign aw_hs      = aw_vld_q && axi_aw_ready;
  assign w_take     = w_vld_q && axi_w_ready;
  assign d_acc      = tlp_d_ready && tlp_d_valid;
  assign last_dword = (beats_q == (LEN+1)'(1)) && (remain_q == 11'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      be_first_q <= '0;
      be_last_q  <= '0;
      first_q    <= 1'b0;
      beats_q    <= '0;
      aw_vld_q   <= 1'b0;
      w_vld_q    <= 1'b0;
      w_last_q   <= 1'b0;
      w_strb_q   <= '0;
      w_dat_q    <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      be_first_q <= be_first_d;
      be_last_q  <= be_last_d;
      first_q    <= first_d;
      beats_q    <= beats_d;
      aw_vld_q   <= aw_vld_d;
      w_vld_q    <= w_vld_d;
      w_last_q   <= w_last_d;
      w_strb_q   <= w_strb_d;
      w_dat_q    <= w_dat_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (h_acc) state_d = S_AW;
      S_AW:    if (aw_hs) state_d = S_W;
      S_W:     if (w_take && w_last_q) state_d = (remain_q == 11'd0) ? S_IDLE : S_AW;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tlp_h_ready  = (state_q == S_IDLE) && !rst;
    tlp_d_ready  = (state_q == S_W) && (beats_q != '0) && (!w_vld_q || axi_w_ready);
    axi_aw_valid = aw_vld_q;
    axi_aw_addr  = {addr_q, 2'b00};
    axi_aw_len   = LEN'(blen - 11'd1);
    axi_w_valid  = w_vld_q;
    axi_w_last   = w_last_q;
    axi_w_strb   = w_strb_q;
    axi_w_data   = w_dat_q;
    axi_b_ready  = 1'b1;
    err_resp     = err_q;
  end

  always_comb begin
    addr_d     = addr_q;
    remain_d   = remain_q;
    be_first_d = be_first_q;
    be_last_d  = be_last_q;
    first_d    = first_q;
    beats_d    = beats_q;
    w_vld_d    = w_vld_q;
    w_last_d   = w_last_q;
    w_strb_d   = w_strb_q;
    w_dat_d    = w_dat_q;
    outst_d    = outst_q;
    err_d      = axi_b_valid && (axi_b_resp != 2'b00);

    if (h_acc) begin
      addr_d     = tlp_h_addr;
      remain_d   = {(tlp_h_len == 10'd0), tlp_h_len};
      be_first_d = tlp_h_be_first;
      be_last_d  = tlp_h_be_last;
      first_d    = 1'b1;
    end

    // Address and remaining count move to the next burst as soon as this one is issued.
    if (aw_hs) begin
      addr_d   = addr_q + (ADDR-2)'(blen);
      remain_d = remain_q - blen;
      beats_d  = blen[LEN:0];
    end

    if (w_take) w_vld_d = 1'b0;
    if (d_acc) begin
      w_vld_d  = 1'b1;
      w_dat_d  = tlp_d_data;
      w_last_d = (beats_q == (LEN+1)'(1));
      w_strb_d = first_q ? be_first_q : (last_dword ? be_last_q : 4'hF);
      first_d  = 1'b0;
      beats_d  = beats_q - (LEN+1)'(1);
    end

    case ({aw_hs, axi_b_valid})
      2'b10:   if (outst_q != 4'hF) outst_d = outst_q + 4'd1;
      2'b01:   if (outst_q != 4'h0) outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    // Uses the post-B count so a freed slot re-opens AW on the very next cycle.
    aw_vld_d = (state_q == S_AW) && !aw_hs && (outst_d != 4'hF);
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_write_core.sv
// Scoreboard bench: directed TLPs push expected AW/W beats; negedge monitors pop and compare.
module tb_dlsc_pcie_s6_inbound_write_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_h_ready, tlp_h_valid;
  logic [31:2] tlp_h_addr;
  logic [9:0]  tlp_h_len;
  logic [3:0]  tlp_h_be_first, tlp_h_be_last;
  logic        tlp_d_ready, tlp_d_valid;
  logic [31:0] tlp_d_data;
  logic        axi_aw_ready, axi_aw_valid;
  logic [31:0] axi_aw_addr;
  logic [3:0]  axi_aw_len;
  logic        axi_w_ready, axi_w_valid, axi_w_last;
  logic [3:0]  axi_w_strb;
  logic [31:0] axi_w_data;
  logic        axi_b_ready, axi_b_valid;
  logic [1:0]  axi_b_resp;
  logic        err_resp;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_write_core #(.ADDR(32), .LEN(4)) dut (
    .clk(clk), .rst(rst),
    .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid), .tlp_h_addr(tlp_h_addr),
    .tlp_h_len(tlp_h_len), .tlp_h_be_first(tlp_h_be_first), .tlp_h_be_last(tlp_h_be_last),
    .tlp_d_ready(tlp_d_ready), .tlp_d_valid(tlp_d_valid), .tlp_d_data(tlp_d_data),
    .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr),
    .axi_aw_len(axi_aw_len),
    .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid), .axi_w_last(axi_w_last),
    .axi_w_strb(axi_w_strb), .axi_w_data(axi_w_data),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
    .err_resp(err_resp)
  );

  typedef struct packed {logic [31:0] addr; logic [3:0] len;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, aw_count = 0, b_count = 0, err_pulses = 0;
  int  last_b_cyc = -100, aw_b_gap = 0;
  bit  b_en = 1'b1, aw_rand = 1'b0, burst_open = 1'b0, prev_err = 1'b0;
  int  w_mode = 0;
  logic [1:0] next_resp = 2'b00;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_err   = 1'b0;
      burst_open = 1'b0;
    end else begin
      chk("err_resp", err_resp, prev_err);
      if (err_resp) err_pulses++;
      prev_err = axi_b_valid && (axi_b_resp != 2'b00);
      if (axi_b_valid) last_b_cyc = cyc;
      if (axi_aw_valid && axi_aw_ready) begin
        aw_count++;
        aw_b_gap   = cyc - last_b_cyc;
        burst_open = 1'b1;
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got addr %0h len %0h, none expected", axi_aw_addr, axi_aw_len);
        end else chk("aw", {axi_aw_addr, axi_aw_len}, aw_q.pop_front());
      end
      if (axi_w_valid && axi_w_ready) begin
        chk("w_after_aw", burst_open, 1'b1);
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got data %0h strb %0h, none expected", axi_w_data, axi_w_strb);
        end else chk("w", {axi_w_data, axi_w_strb, axi_w_last}, w_q.pop_front());
        if (axi_w_last) burst_open = 1'b0;
      end
    end
  end

  // AXI slave: one B per accepted AW, one cycle wide, when enabled.
  initial begin
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (axi_b_valid) begin
        axi_b_valid = 1'b0;
        axi_b_resp  = 2'b00;
        b_count++;
      end else if (b_en && aw_count > b_count) begin
        axi_b_valid = 1'b1;
        axi_b_resp  = next_resp;
        next_resp   = 2'b00;
      end
    end
  end

  initial begin
    axi_w_ready  = 1'b1;
    axi_aw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      axi_w_ready  = (w_mode == 1) ? 1'($urandom_range(0, 1)) : (w_mode == 0);
      axi_aw_ready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_tlp(input logic [31:0] addr, input int len, input logic [3:0] bef,
                          input logic [3:0] bel, input logic [31:0] base);
    int t;
    @(posedge clk); #1;
    tlp_h_valid = 1'b1; tlp_h_addr = addr[31:2]; tlp_h_len = len[9:0];
    tlp_h_be_first = bef; tlp_h_be_last = bel;
    t = 0;
    @(negedge clk);
    while (!tlp_h_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin checks++; errors++; $display("FAIL hdr_timeout: got no ready, required ready"); end
    @(posedge clk); #1;
    tlp_h_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      tlp_d_valid = 1'b1; tlp_d_data = base + i;
      t = 0;
      @(negedge clk);
      while (!tlp_d_ready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin checks++; errors++; $display("FAIL data_timeout: got no ready, required ready"); end
      @(posedge clk); #1;
    end
    tlp_d_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((aw_q.size() != 0 || w_q.size() != 0 || b_count != aw_count || tlp_h_ready !== 1'b1) && t < 3000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL idle_timeout: got aw_left=%0d w_left=%0d, required 0", aw_q.size(), w_q.size());
    end
  endtask

  function automatic void exp_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    w_q.push_back('{data: d, strb: s, last: l});
  endfunction

  initial begin
    int base, n;
    rst = 1'b1; tlp_h_valid = 1'b0; tlp_h_addr = '0; tlp_h_len = '0;
    tlp_h_be_first = '0; tlp_h_be_last = '0; tlp_d_valid = 1'b0; tlp_d_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_valid", axi_aw_valid, 1'b0);
    chk("rst_w_valid", axi_w_valid, 1'b0);
    chk("rst_err", err_resp, 1'b0);
    chk("rst_d_ready", tlp_d_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("h_ready_after_rst", tlp_h_ready, 1'b1);
    chk("b_ready", axi_b_ready, 1'b1);

    // single dword, partial strobe
    aw_q.push_back('{addr: 32'h1000, len: 4'd0});
    exp_w(32'hA000_0000, 4'h3, 1'b1);
    send_tlp(32'h1000, 1, 4'h3, 4'hF, 32'hA000_0000);
    wait_idle();

    // 4KB crossing: 2 dwords before the page edge, 4 after
    aw_q.push_back('{addr: 32'h0FF8, len: 4'd1});
    aw_q.push_back('{addr: 32'h1000, len: 4'd3});
    exp_w(32'hB000_0000, 4'hF, 1'b0); exp_w(32'hB000_0001, 4'hF, 1'b1);
    exp_w(32'hB000_0002, 4'hF, 1'b0); exp_w(32'hB000_0003, 4'hF, 1'b0);
    exp_w(32'hB000_0004, 4'hF, 1'b0); exp_w(32'hB000_0005, 4'h1, 1'b1);
    send_tlp(32'h0FF8, 6, 4'hF, 4'h1, 32'hB000_0000);
    wait_idle();

    // 40 dwords -> 16 + 16 + 8
    aw_q.push_back('{addr: 32'h2000, len: 4'd15});
    aw_q.push_back('{addr: 32'h2040, len: 4'd15});
    aw_q.push_back('{addr: 32'h2080, len: 4'd7});
    for (int i = 0; i < 40; i++)
      exp_w(32'hC000_0000 + i, (i == 0) ? 4'hE : (i == 39) ? 4'h3 : 4'hF, (i == 15 || i == 31 || i == 39));
    send_tlp(32'h2000, 40, 4'hE, 4'h3, 32'hC000_0000);
    wait_idle();

    // SLVERR response
    n = err_pulses;
    next_resp = 2'b10;
    aw_q.push_back('{addr: 32'h4000, len: 4'd0});
    exp_w(32'hD000_0000, 4'hF, 1'b1);
    send_tlp(32'h4000, 1, 4'hF, 4'hF, 32'hD000_0000);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("err_pulse_count", err_pulses - n, 1);

    // random W/AW ready: 4 dwords to page edge then 5
    w_mode = 1; aw_rand = 1'b1;
    aw_q.push_back('{addr: 32'h3FF0, len: 4'd3});
    aw_q.push_back('{addr: 32'h4000, len: 4'd4});
    exp_w(32'hE000_0000, 4'hC, 1'b0); exp_w(32'hE000_0001, 4'hF, 1'b0);
    exp_w(32'hE000_0002, 4'hF, 1'b0); exp_w(32'hE000_0003, 4'hF, 1'b1);
    exp_w(32'hE000_0004, 4'hF, 1'b0); exp_w(32'hE000_0005, 4'hF, 1'b0);
    exp_w(32'hE000_0006, 4'hF, 1'b0); exp_w(32'hE000_0007, 4'hF, 1'b0);
    exp_w(32'hE000_0008, 4'h7, 1'b1);
    send_tlp(32'h3FF0, 9, 4'hC, 4'h7, 32'hE000_0000);
    wait_idle();
    w_mode = 0; aw_rand = 1'b0;
    repeat (2) @(posedge clk);

    // outstanding limit: B withheld, 16th AW waits for first B
    b_en = 1'b0;
    base = aw_count;
    for (int i = 0; i < 16; i++) begin
      aw_q.push_back('{addr: 32'h5000 + 4 * i, len: 4'd0});
      exp_w(32'hF000_0000 + i, 4'hF, 1'b1);
    end
    for (int i = 0; i < 15; i++) send_tlp(32'h5000 + 4 * i, 1, 4'hF, 4'hF, 32'hF000_0000 + i);
    fork
      send_tlp(32'h503C, 1, 4'hF, 4'hF, 32'hF000_000F);
      begin
        repeat (40) @(posedge clk);
        chk("aw_limit_15", aw_count - base, 15);
        b_en = 1'b1;
      end
    join
    wait_idle();
    chk("aw16_after_b", aw_b_gap, 1);

    // reset mid-burst with W stalled
    w_mode = 2;
    aw_q.push_back('{addr: 32'h6000, len: 4'd7});
    @(posedge clk); #1;
    tlp_h_valid = 1'b1; tlp_h_addr = 30'h1800; tlp_h_len = 10'd8;
    tlp_h_be_first = 4'hF; tlp_h_be_last = 4'hF;
    @(posedge clk); #1;
    tlp_h_valid = 1'b0; tlp_d_valid = 1'b1; tlp_d_data = 32'h1234_0000;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; tlp_d_valid = 1'b0; w_mode = 0;
    chk("aw_before_rst", aw_q.size(), 0);
    w_q.delete();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_aw_valid || axi_w_valid) n++;
    end
    chk("no_beats_after_rst", n, 0);
    chk("h_ready_post_abort", tlp_h_ready, 1'b1);
    chk("d_ready_post_abort", tlp_d_ready, 1'b0);

    aw_q.push_back('{addr: 32'h7000, len: 4'd1});
    exp_w(32'h7700_0000, 4'h1, 1'b0);
    exp_w(32'h7700_0001, 4'h8, 1'b1);
    send_tlp(32'h7000, 2, 4'h1, 4'h8, 32'h7700_0000);
    wait_idle();

    chk("aw_queue_empty", aw_q.size(), 0);
    chk("w_queue_empty", w_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
